// File: rtl/muldiv_ctrl.sv
// Sequencer between the control unit and the iterative multiplier/divider:
// issues start pulses, times each unit's fixed latency, owns HI/LO.
module muldiv_ctrl #(
    parameter int MULT_LAT = 36,
    parameter int DIV_LAT  = 34,
    parameter int CNT_W    = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    input  logic [2:0]  cmd_op,
    input  logic [31:0] op_b,
    input  logic [31:0] mt_data,
    output logic        cmd_ready,
    output logic        stall,
    output logic        mult_start,
    output logic        div_start,
    input  logic [31:0] mult_hi,
    input  logic [31:0] mult_lo,
    input  logic [31:0] div_hi,
    input  logic [31:0] div_lo,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mf_data,
    output logic        mf_valid,
    output logic        done,
    output logic        div_zero
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN_MULT,
        S_RUN_DIV
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_MULT = 3'b001,
        OP_DIV  = 3'b010,
        OP_MFHI = 3'b011,
        OP_MFLO = 3'b100,
        OP_MTHI = 3'b101,
        OP_MTLO = 3'b110,
        OP_RSVD = 3'b111
    } op_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_next_cnt;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic [31:0]        r_mf_data;
    logic               r_mf_valid;
    logic               r_done;
    logic               r_div_zero;

    op_t                w_op;
    logic               w_accept;
    logic               w_capture;
    logic               w_mult_go;
    logic               w_div_go;
    logic               w_div_zero_go;

    assign w_op = op_t'(cmd_op);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // Start pulses are combinational so the units sample the accept-cycle operands.
    always_comb begin
        w_next_state  = r_state;
        w_next_cnt    = r_cnt;
        w_accept      = 1'b0;
        w_capture     = 1'b0;
        w_mult_go     = 1'b0;
        w_div_go      = 1'b0;
        w_div_zero_go = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_accept = cmd_valid & ~reset;
                if (w_accept && w_op == OP_MULT) begin
                    w_mult_go    = 1'b1;
                    w_next_state = S_RUN_MULT;
                    w_next_cnt   = CNT_W'(MULT_LAT - 1);
                end else if (w_accept && w_op == OP_DIV) begin
                    if (op_b != '0) begin
                        w_div_go     = 1'b1;
                        w_next_state = S_RUN_DIV;
                        w_next_cnt   = CNT_W'(DIV_LAT - 1);
                    end else begin
                        w_div_zero_go = 1'b1;
                    end
                end
            end
            S_RUN_MULT, S_RUN_DIV: begin
                if (r_cnt == '0) begin
                    w_capture    = 1'b1;
                    w_next_state = S_IDLE;
                end else begin
                    w_next_cnt = r_cnt - 1'b1;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi       <= '0;
            r_lo       <= '0;
            r_mf_data  <= '0;
            r_mf_valid <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_mf_valid <= 1'b0;
            r_done     <= w_capture;
            r_div_zero <= w_div_zero_go;
            if (w_capture) begin
                if (r_state == S_RUN_MULT) begin
                    r_hi <= mult_hi;
                    r_lo <= mult_lo;
                end else begin
                    r_hi <= div_hi;
                    r_lo <= div_lo;
                end
            end
            if (w_accept) begin
                case (w_op)
                    OP_MFHI: begin
                        r_mf_data  <= r_hi;
                        r_mf_valid <= 1'b1;
                    end
                    OP_MFLO: begin
                        r_mf_data  <= r_lo;
                        r_mf_valid <= 1'b1;
                    end
                    OP_MTHI: r_hi <= mt_data;
                    OP_MTLO: r_lo <= mt_data;
                    default: ;
                endcase
            end
        end
    end

    assign cmd_ready  = (r_state == S_IDLE);
    assign stall      = cmd_valid & ~cmd_ready;
    assign mult_start = w_mult_go;
    assign div_start  = w_div_go;
    assign hi         = r_hi;
    assign lo         = r_lo;
    assign mf_data    = r_mf_data;
    assign mf_valid   = r_mf_valid;
    assign done       = r_done;
    assign div_zero   = r_div_zero;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl with behavioural multiplier/divider models
// whose result ports carry junk except in the exact sampling cycle.
module tb_muldiv_ctrl;

    localparam int MULT_LAT = 36;
    localparam int DIV_LAT  = 34;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic [2:0]  cmd_op;
    logic [31:0] op_b;
    logic [31:0] mt_data;
    logic        cmd_ready, stall, mult_start, div_start;
    logic [31:0] mult_hi, mult_lo, div_hi, div_lo;
    logic [31:0] hi, lo, mf_data;
    logic        mf_valid, done, div_zero;

    logic [31:0] tb_a;

    int total = 0;
    int bad   = 0;

    logic [31:0] mfq[$];
    logic [63:0] doneq[$];

    always #5 clk = ~clk;

    muldiv_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
        .op_b(op_b), .mt_data(mt_data), .cmd_ready(cmd_ready), .stall(stall),
        .mult_start(mult_start), .div_start(div_start),
        .mult_hi(mult_hi), .mult_lo(mult_lo), .div_hi(div_hi), .div_lo(div_lo),
        .hi(hi), .lo(lo), .mf_data(mf_data), .mf_valid(mf_valid),
        .done(done), .div_zero(div_zero)
    );

    // Unit models: result valid only in the cycle LAT after the start cycle.
    logic [63:0] m_prod;
    int          m_cnt;
    logic        m_act;
    logic [31:0] d_q, d_r;
    int          d_cnt;
    logic        d_act;

    always @(posedge clk) begin
        if (reset) begin
            m_act <= 1'b0; m_cnt <= 0;
            d_act <= 1'b0; d_cnt <= 0;
        end else begin
            if (mult_start) begin
                m_act  <= 1'b1;
                m_cnt  <= 1;
                m_prod <= {{32{tb_a[31]}}, tb_a} * {{32{op_b[31]}}, op_b};
            end else if (m_act) begin
                m_cnt <= m_cnt + 1;
                if (m_cnt >= MULT_LAT) m_act <= 1'b0;
            end
            if (div_start) begin
                d_act <= 1'b1;
                d_cnt <= 1;
                d_q   <= $signed(tb_a) / $signed(op_b);
                d_r   <= $signed(tb_a) % $signed(op_b);
            end else if (d_act) begin
                d_cnt <= d_cnt + 1;
                if (d_cnt >= DIV_LAT) d_act <= 1'b0;
            end
        end
    end

    assign mult_hi = (m_act && m_cnt == MULT_LAT) ? m_prod[63:32] : 32'hBAD0_0000 + 32'(m_cnt);
    assign mult_lo = (m_act && m_cnt == MULT_LAT) ? m_prod[31:0]  : 32'hBAD1_0000 + 32'(m_cnt);
    assign div_hi  = (d_act && d_cnt == DIV_LAT)  ? d_r : 32'hBAD2_0000 + 32'(d_cnt);
    assign div_lo  = (d_act && d_cnt == DIV_LAT)  ? d_q : 32'hBAD3_0000 + 32'(d_cnt);

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Scoreboard: pulses pop expectations pushed when the command was driven.
    always @(negedge clk) begin
        chk("pulse_excl", 64'($countones({mf_valid, done, div_zero}) <= 1), 64'd1);
        if (mf_valid) begin
            chk("mf_pending", 64'(mfq.size() > 0), 64'd1);
            if (mfq.size() > 0) chk("sb_mf_data", 64'(mf_data), 64'(mfq.pop_front()));
        end
        if (done) begin
            chk("done_pending", 64'(doneq.size() > 0), 64'd1);
            if (doneq.size() > 0) chk("sb_hilo", {hi, lo}, doneq.pop_front());
        end
    end

    task automatic run_wait(input logic [2:0] hold_op, output int n, output int st);
        n  = 0;
        st = 0;
        do begin
            @(posedge clk); #1;
            cmd_op = hold_op;
            n++;
            if (stall) st++;
        end while (!done && n < 80);
    endtask

    typedef struct {
        logic        v;
        logic [2:0]  op;
        logic [31:0] b;
        logic [31:0] mt;
        logic [31:0] ehi;
        logic [31:0] elo;
        logic        emfv;
        logic [31:0] emf;
        logic        edz;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int n, st;
        tbl[0] = '{1'b1, 3'b010, 32'd0, 32'd0,          32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 32'd0,        1'b1};
        tbl[1] = '{1'b1, 3'b101, 32'd1, 32'hDEADBEEF,   32'hDEADBEEF, 32'hFFFFFFEB, 1'b0, 32'd0,        1'b0};
        tbl[2] = '{1'b1, 3'b011, 32'd1, 32'd0,          32'hDEADBEEF, 32'hFFFFFFEB, 1'b1, 32'hDEADBEEF, 1'b0};
        tbl[3] = '{1'b1, 3'b100, 32'd1, 32'd0,          32'hDEADBEEF, 32'hFFFFFFEB, 1'b1, 32'hFFFFFFEB, 1'b0};
        tbl[4] = '{1'b1, 3'b110, 32'd0, 32'h12345678,   32'hDEADBEEF, 32'h12345678, 1'b0, 32'd0,        1'b0};
        tbl[5] = '{1'b1, 3'b000, 32'd0, 32'h55555555,   32'hDEADBEEF, 32'h12345678, 1'b0, 32'd0,        1'b0};
        tbl[6] = '{1'b1, 3'b111, 32'd0, 32'hAAAAAAAA,   32'hDEADBEEF, 32'h12345678, 1'b0, 32'd0,        1'b0};
        tbl[7] = '{1'b0, 3'b101, 32'd0, 32'h00000000,   32'hDEADBEEF, 32'h12345678, 1'b0, 32'd0,        1'b0};
        tbl[8] = '{1'b1, 3'b100, 32'd0, 32'd0,          32'hDEADBEEF, 32'h12345678, 1'b1, 32'h12345678, 1'b0};

        // Reset with a MULT presented: no start pulse may leak out.
        reset = 1'b1; cmd_valid = 1'b1; cmd_op = 3'b001; op_b = 32'd5; mt_data = '0; tb_a = 32'd3;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_no_start", 64'(mult_start), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0; cmd_valid = 1'b0;
        chk("rst_ready", 64'(cmd_ready), 64'd1);
        chk("rst_hilo", {hi, lo}, 64'd0);
        chk("rst_mf_data", 64'(mf_data), 64'd0);
        chk("rst_pulses", 64'({mf_valid, done, div_zero}), 64'd0);
        @(negedge clk);
        chk("rst_stall", 64'(stall), 64'd0);

        // MULT 7 * -3
        @(posedge clk); #1;
        tb_a = 32'd7; op_b = 32'hFFFFFFFD; cmd_op = 3'b001; cmd_valid = 1'b1;
        doneq.push_back(64'hFFFFFFFF_FFFFFFEB);
        @(negedge clk);
        chk("t1_mult_start", 64'(mult_start), 64'd1);
        chk("t1_div_start", 64'(div_start), 64'd0);
        chk("t1_stall0", 64'(stall), 64'd0);
        run_wait(3'b000, n, st);
        cmd_valid = 1'b0;
        chk("t1_done_cycle", 64'(n), 64'(MULT_LAT + 1));
        chk("t1_stall_cycles", 64'(st), 64'(MULT_LAT));
        chk("t1_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);

        // Single-cycle IDLE commands, back to back
        for (int i = 0; i < 9; i++) begin
            cmd_valid = tbl[i].v; cmd_op = tbl[i].op; op_b = tbl[i].b; mt_data = tbl[i].mt;
            if (tbl[i].emfv) mfq.push_back(tbl[i].emf);
            @(negedge clk);
            chk($sformatf("tbl%0d_ready", i), 64'(cmd_ready), 64'd1);
            chk($sformatf("tbl%0d_dstart", i), 64'({div_start, mult_start}), 64'd0);
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_hi", i), 64'(hi), 64'(tbl[i].ehi));
            chk($sformatf("tbl%0d_lo", i), 64'(lo), 64'(tbl[i].elo));
            chk($sformatf("tbl%0d_mfv", i), 64'(mf_valid), 64'(tbl[i].emfv));
            chk($sformatf("tbl%0d_dz", i), 64'(div_zero), 64'(tbl[i].edz));
        end
        cmd_valid = 1'b0;

        // DIV 100 / 7
        tb_a = 32'd100; op_b = 32'd7; cmd_op = 3'b010; cmd_valid = 1'b1;
        doneq.push_back(64'h00000002_0000000E);
        @(negedge clk);
        chk("t3_div_start", 64'(div_start), 64'd1);
        chk("t3_mult_start", 64'(mult_start), 64'd0);
        run_wait(3'b000, n, st);
        cmd_valid = 1'b0;
        chk("t3_done_cycle", 64'(n), 64'(DIV_LAT + 1));
        chk("t3_stall_cycles", 64'(st), 64'(DIV_LAT));
        chk("t3_hilo", {hi, lo}, 64'h00000002_0000000E);

        // MFLO held behind a MULT returns the freshly captured LO
        @(posedge clk); #1;
        tb_a = 32'h00012345; op_b = 32'h00010001; cmd_op = 3'b001; cmd_valid = 1'b1;
        doneq.push_back(64'h00000001_23462345);
        mfq.push_back(32'h23462345);
        @(negedge clk);
        chk("t4_mult_start", 64'(mult_start), 64'd1);
        run_wait(3'b100, n, st);
        chk("t4_accept_cycle", 64'(n), 64'(MULT_LAT + 1));
        chk("t4_stall_cycles", 64'(st), 64'(MULT_LAT));
        chk("t4_ready", 64'(cmd_ready), 64'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("t4_mf_valid", 64'(mf_valid), 64'd1);
        chk("t4_mf_data", 64'(mf_data), 64'h23462345);

        // Reset in cycle 10 of a MULT run aborts without capture
        @(posedge clk); #1;
        tb_a = 32'd5; op_b = 32'd6; cmd_op = 3'b001; cmd_valid = 1'b1;
        @(negedge clk);
        chk("t6_mult_start", 64'(mult_start), 64'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("t6_busy_at_10", 64'(cmd_ready), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        chk("t6_ready", 64'(cmd_ready), 64'd1);
        chk("t6_hilo", {hi, lo}, 64'd0);
        chk("t6_no_done", 64'(done), 64'd0);
        cmd_op = 3'b001; cmd_valid = 1'b1;
        doneq.push_back(64'h00000000_0000001E);
        @(negedge clk);
        chk("t6_restart", 64'(mult_start), 64'd1);
        run_wait(3'b000, n, st);
        cmd_valid = 1'b0;
        chk("t6_done_cycle", 64'(n), 64'(MULT_LAT + 1));
        chk("t6_hilo_new", {hi, lo}, 64'h00000000_0000001E);

        repeat (3) @(posedge clk);
        #1;
        chk("mfq_drained", 64'(mfq.size()), 64'd0);
        chk("doneq_drained", 64'(doneq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Sequencer between the control unit and the iterative multiplier/divider units of the MIPS datapath.
- Accepts one command per idle cycle: MULT, DIV, MFHI, MFLO, MTHI, MTLO.
- Issues single-cycle start pulses to the multiplier or divider and counts each unit's fixed latency.
- Captures results into the architectural HI/LO registers and stalls the control unit while an operation is in flight.

Parameters:
MULT_LAT, 36, cycles from the start cycle (cycle 0) to the cycle in which multiplier result ports are sampled.
DIV_LAT, 34, same for divider result ports.
CNT_W, 6, down-counter width; must hold max(MULT_LAT, DIV_LAT).

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
cmd_valid  in  1  control unit presents a command
cmd_op  in  3  000 NOP, 001 MULT, 010 DIV, 011 MFHI, 100 MFLO, 101 MTHI, 110 MTLO, 111 reserved (treated as NOP)
op_b  in  32  divisor operand (rt value), checked for zero on DIV
mt_data  in  32  rs value for MTHI/MTLO
cmd_ready  out  1  high only in IDLE
stall  out  1  cmd_valid & ~cmd_ready, combinational
mult_start  out  1  one-cycle pulse to multiplier (its multOP)
div_start  out  1  one-cycle pulse to divider
mult_hi, mult_lo  in  32 each  multiplier result ports
div_hi, div_lo  in  32 each  divider remainder / quotient
hi, lo  out  32 each  architectural HI/LO registers
mf_data  out  32  registered MFHI/MFLO read data
mf_valid  out  1  one-cycle pulse, mf_data valid
done  out  1  one-cycle pulse on the HI/LO capture edge
div_zero  out  1  one-cycle pulse, DIV by zero rejected

Behaviour:
- Reset is synchronous and has priority over everything:
  - state := IDLE, counter := 0.
  - hi, lo, mf_data := 0.
  - mf_valid, done, div_zero := 0.
  - No start pulse is issued in a reset cycle. Units share the same reset.
- States: IDLE, RUN_MULT, RUN_DIV.
- Accept condition: state == IDLE and cmd_valid. A command is accepted only under this condition; in RUN states it is not accepted and stall = 1 (the control unit holds it).
- mult_start = accept & (cmd_op == MULT), combinational, so the operands the unit samples are those present in the accept cycle.
- div_start = accept & (cmd_op == DIV) & (op_b != 0), combinational.
- MULT accepted: state -> RUN_MULT, counter := MULT_LAT-1.
- DIV accepted:
  - op_b != 0: state -> RUN_DIV, counter := DIV_LAT-1.
  - op_b == 0: no start pulse; div_zero = 1 next cycle; HI/LO unchanged; stay IDLE.
- RUN_x, counter > 0: counter decrements each cycle.
- RUN_x, counter == 0 (cycle MULT_LAT or DIV_LAT after start):
  - At that edge: hi := x_hi, lo := x_lo; done = 1 next cycle; state -> IDLE.
  - cmd_ready is still 0 during this capture cycle, so a command can be accepted no earlier than the following cycle.
- MFHI/MFLO accepted: mf_data := hi or lo at the edge; mf_valid = 1 next cycle; state stays IDLE. Back-to-back MF commands give a pulse every cycle.
- MTHI/MTLO accepted: hi or lo := mt_data at the edge; state stays IDLE.
- NOP or reserved op: no effect, even when accepted.
- MF immediately after MULT: stalled through the whole run. Accepted the first IDLE cycle; returns the new value.
- Reset mid-run: abort to IDLE with no capture and no done.
- Result ports are ignored outside the capture edge.
- The controller performs no sign handling; the units own the arithmetic.
- Outputs mf_valid, done and div_zero are registered and never high together in the same cycle.

Test Plan:
1. Reset, then MULT with bench multiplier model (A=7, B=-3) -> mult_start for 1 cycle; stall high for 36 cycles; done at cycle 37; hi=FFFFFFFF, lo=FFFFFFEB.
2. DIV with op_b=0 -> no div_start; div_zero pulse next cycle; hi/lo unchanged; cmd_ready stays 1.
3. DIV 100/7 with model -> div_start pulse; capture at cycle 34; lo=0000000E, hi=00000002; done pulse.
4. MFLO held valid immediately after MULT -> stall high until the capture cycle inclusive; accepted next cycle; mf_valid with the new lo.
5. MTHI 0xDEADBEEF then MFHI then MFLO on consecutive cycles -> hi=DEADBEEF; mf_valid two consecutive cycles with DEADBEEF then the current lo.
6. reset asserted at cycle 10 of RUN_MULT -> IDLE next cycle; hi=lo=0; no done; a new MULT is accepted right after reset deasserts.
